wireframe_line_drawer: RTL and testbench

Rasterises 2D line segments into the wireframe SRAM, one pixel per clock, using integer Bresenham stepping. Also performs a whole-frame clear. Sits directly upstream of `wireframe_sram`: it drives that block's `write_en`, `data_in` and `addr` ports, and accepts commands from the projection/edge stage through a valid/ready handshake. The SRAM is addressed row-major with a stride of WIDTH+1, because column WIDTH of each row holds that row's parity bit.

---
 rtl/wireframe_line_drawer.sv | 188 ++++++++++++++++++
 tb/tb_wireframe_line_drawer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/wireframe_line_drawer.sv
// Bresenham line rasteriser and frame clearer driving the wireframe SRAM write port.
// One pixel (or clear word) per clock; SRAM rows have a stride of WIDTH+1 for the parity column.
module wireframe_line_drawer #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int ADDR_W = 19,
  parameter int XY_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [XY_W-1:0]   x0,
  input  logic [XY_W-1:0]   y0,
  input  logic [XY_W-1:0]   x1,
  input  logic [XY_W-1:0]   y1,
  input  logic              clear_req,
  output logic              busy,
  output logic              done,
  output logic              done_err,
  output logic              sram_write_en,
  output logic              sram_data_in,
  output logic [ADDR_W-1:0] sram_addr
);

  localparam int EW = XY_W + 2;
  localparam logic [ADDR_W-1:0] ROW_A   = ADDR_W'(WIDTH + 1);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'((WIDTH + 1) * HEIGHT - 1);
  localparam logic [XY_W:0]     WIDTH_L  = (XY_W + 1)'(WIDTH);
  localparam logic [XY_W:0]     HEIGHT_L = (XY_W + 1)'(HEIGHT);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_DRAW, S_CLEAR, S_DONE} state_t;

  function automatic logic signed [EW-1:0] abs_diff(input logic [XY_W-1:0] a,
                                                     input logic [XY_W-1:0] b);
    logic [XY_W-1:0] d;
    d = (a >= b) ? (a - b) : (b - a);
    return $signed({2'b00, d});
  endfunction

  state_t state;

  logic [XY_W-1:0]        lx0, ly0, lx1, ly1;
  logic [XY_W-1:0]        cx, cy;
  logic signed [EW-1:0]   dx, dy, err;
  logic                   sx_neg, sy_neg;

  logic                   range_bad;
  logic [ADDR_W-1:0]      addr0;
  logic signed [EW-1:0]   dx0, dy0;

  logic signed [EW:0]     e2, dx_w, dy_w;
  logic                   step_x, step_y, at_end;
  logic signed [EW-1:0]   err_next;
  logic [XY_W-1:0]        x_next, y_next;
  logic [ADDR_W-1:0]      addr_next;

  // Setup: range check and Bresenham initial terms from the latched endpoints
  always_comb begin
    range_bad = ({1'b0, lx0} >= WIDTH_L)  || ({1'b0, lx1} >= WIDTH_L) ||
                ({1'b0, ly0} >= HEIGHT_L) || ({1'b0, ly1} >= HEIGHT_L);
    addr0     = ADDR_W'(ly0) * ROW_A + ADDR_W'(lx0);
    dx0       = abs_diff(lx1, lx0);
    dy0       = -abs_diff(ly1, ly0);
  end

  // Draw: both axis decisions use the error term from before this step
  always_comb begin
    e2       = {err, 1'b0};
    dx_w     = (EW + 1)'(dx);
    dy_w     = (EW + 1)'(dy);
    step_x   = (e2 >= dy_w);
    step_y   = (e2 <= dx_w);
    at_end   = (cx == lx1) && (cy == ly1);
    err_next = err;
    x_next   = cx;
    y_next   = cy;
    addr_next = sram_addr;
    if (step_x) begin
      err_next  = err_next + dy;
      x_next    = sx_neg ? (cx - 1'b1) : (cx + 1'b1);
      addr_next = sx_neg ? (addr_next - 1'b1) : (addr_next + 1'b1);
    end
    if (step_y) begin
      err_next  = err_next + dx;
      y_next    = sy_neg ? (cy - 1'b1) : (cy + 1'b1);
      addr_next = sy_neg ? (addr_next - ROW_A) : (addr_next + ROW_A);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      cmd_ready     <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      done_err      <= 1'b0;
      sram_write_en <= 1'b0;
      sram_data_in  <= 1'b0;
      sram_addr     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (clear_req) begin
            state         <= S_CLEAR;
            cmd_ready     <= 1'b0;
            busy          <= 1'b1;
            sram_write_en <= 1'b1;
            sram_data_in  <= 1'b0;
            sram_addr     <= '0;
          end else if (cmd_valid) begin
            state     <= S_SETUP;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        S_SETUP: begin
          if (range_bad) begin
            state    <= S_DONE;
            done     <= 1'b1;
            done_err <= 1'b1;
          end else begin
            state         <= S_DRAW;
            sram_write_en <= 1'b1;
            sram_data_in  <= 1'b1;
            sram_addr     <= addr0;
          end
        end
        S_DRAW: begin
          if (at_end) begin
            state         <= S_DONE;
            sram_write_en <= 1'b0;
            done          <= 1'b1;
          end else begin
            sram_addr <= addr_next;
          end
        end
        S_CLEAR: begin
          if (sram_addr == LAST_A) begin
            state         <= S_DONE;
            sram_write_en <= 1'b0;
            done          <= 1'b1;
          end else begin
            sram_addr <= sram_addr + 1'b1;
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          done      <= 1'b0;
          done_err  <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath registers carry no reset; they are always loaded before use
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: begin
        if (cmd_valid && !clear_req) begin
          lx0 <= x0;
          ly0 <= y0;
          lx1 <= x1;
          ly1 <= y1;
        end
      end
      S_SETUP: begin
        cx     <= lx0;
        cy     <= ly0;
        dx     <= dx0;
        dy     <= dy0;
        err    <= dx0 + dy0;
        sx_neg <= (lx1 < lx0);
        sy_neg <= (ly1 < ly0);
      end
      S_DRAW: begin
        cx  <= x_next;
        cy  <= y_next;
        err <= err_next;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wireframe_line_drawer.sv
// Directed bench for wireframe_line_drawer: line timing/addresses, range reject, reset abort, clear priority.
module tb_wireframe_line_drawer;

  logic        clk = 1'b0;
  logic        rst;

  logic        cmd_valid, clear_req;
  logic [9:0]  x0, y0, x1, y1;
  logic        cmd_ready, busy, done, done_err, sram_write_en, sram_data_in;
  logic [18:0] sram_addr;

  logic        cmd_valid_b, clear_req_b;
  logic [9:0]  xb0, yb0, xb1, yb1;
  logic        cmd_ready_b, busy_b, done_b, done_err_b, we_b, data_b;
  logic [18:0] addr_b;

  int n_chk = 0;
  int n_err = 0;
  int exp_addr[8];
  int exp_n;

  always #5 clk = ~clk;

  wireframe_line_drawer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .clear_req(clear_req),
    .busy(busy), .done(done), .done_err(done_err),
    .sram_write_en(sram_write_en), .sram_data_in(sram_data_in), .sram_addr(sram_addr)
  );

  wireframe_line_drawer #(.WIDTH(4), .HEIGHT(2), .ADDR_W(19), .XY_W(10)) dut_small (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .x0(xb0), .y0(yb0), .x1(xb1), .y1(yb1), .clear_req(clear_req_b),
    .busy(busy_b), .done(done_b), .done_err(done_err_b),
    .sram_write_en(we_b), .sram_data_in(data_b), .sram_addr(addr_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one line command on the full-size instance and compare against exp_addr/exp_n
  task automatic run_line(input logic [9:0] a0, input logic [9:0] b0,
                          input logic [9:0] a1, input logic [9:0] b1,
                          input logic exp_e);
    int wa[$];
    int wc[$];
    int wd[$];
    int done_cyc;
    int n_exp;
    done_cyc = -1;
    n_exp = exp_e ? 0 : exp_n;
    @(negedge clk);
    chk("ready_idle", 32'(cmd_ready), 1);
    x0 = a0; y0 = b0; x1 = a1; y1 = b1;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) chk("busy_c1", 32'(busy), 1);
      if (sram_write_en) begin
        wa.push_back(int'(sram_addr));
        wc.push_back(c);
        wd.push_back(int'(sram_data_in));
      end
      if (done_cyc < 0 && done) begin
        done_cyc = c;
        chk("done_err", 32'(done_err), 32'(exp_e));
        chk("busy_done", 32'(busy), 1);
      end else if (done_cyc >= 0 && c == done_cyc + 1) begin
        chk("done_pulse", 32'(done), 0);
        chk("ready_back", 32'(cmd_ready), 1);
        break;
      end
    end
    chk("done_cycle", 32'(done_cyc), exp_e ? 32'd2 : 32'(2 + exp_n));
    chk("n_writes", 32'(wa.size()), 32'(n_exp));
    for (int i = 0; i < wa.size() && i < n_exp; i++) begin
      chk("w_addr", 32'(wa[i]), 32'(exp_addr[i]));
      chk("w_cycle", 32'(wc[i]), 32'(2 + i));
      chk("w_data", 32'(wd[i]), 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int nw, nd;
    int exp_we, exp_dn, exp_a, exp_d;
    rst = 1'b1;
    cmd_valid = 1'b0; clear_req = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    cmd_valid_b = 1'b0; clear_req_b = 1'b0;
    xb0 = '0; yb0 = '0; xb1 = '0; yb1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_we", 32'(sram_write_en), 0);
    chk("rst_addr", 32'(sram_addr), 0);
    rst = 1'b0;

    exp_n = 4; exp_addr[0] = 0; exp_addr[1] = 1; exp_addr[2] = 2; exp_addr[3] = 3;
    run_line(10'd0, 10'd0, 10'd3, 10'd0, 1'b0);

    exp_n = 4; exp_addr[0] = 0; exp_addr[1] = 641; exp_addr[2] = 1283; exp_addr[3] = 1924;
    run_line(10'd0, 10'd0, 10'd1, 10'd3, 1'b0);

    exp_n = 3; exp_addr[0] = 1284; exp_addr[1] = 642; exp_addr[2] = 0;
    run_line(10'd2, 10'd2, 10'd0, 10'd0, 1'b0);

    exp_n = 1; exp_addr[0] = 648;
    run_line(10'd7, 10'd1, 10'd7, 10'd1, 1'b0);

    exp_n = 0;
    run_line(10'd0, 10'd0, 10'd640, 10'd0, 1'b1);

    // Reset in cycle 3 of a 10-pixel line
    @(negedge clk);
    x0 = 10'd0; y0 = 10'd0; x1 = 10'd9; y1 = 10'd0;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_we", 32'(sram_write_en), 1);
    chk("pre_rst_addr", 32'(sram_addr), 1);
    rst = 1'b1;
    #1;
    chk("abort_we", 32'(sram_write_en), 0);
    chk("abort_addr", 32'(sram_addr), 0);
    chk("abort_data", 32'(sram_data_in), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_err", 32'(done_err), 0);
    chk("abort_ready", 32'(cmd_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    nw = 0; nd = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (sram_write_en) nw++;
      if (done) nd++;
    end
    chk("post_rst_writes", 32'(nw), 0);
    chk("post_rst_dones", 32'(nd), 0);
    exp_n = 4; exp_addr[0] = 0; exp_addr[1] = 1; exp_addr[2] = 2; exp_addr[3] = 3;
    run_line(10'd0, 10'd0, 10'd3, 10'd0, 1'b0);

    // Clear beats a simultaneous line command on the 4x2 instance
    @(negedge clk);
    chk("b_ready_idle", 32'(cmd_ready_b), 1);
    xb0 = 10'd0; yb0 = 10'd0; xb1 = 10'd1; yb1 = 10'd0;
    cmd_valid_b = 1'b1;
    clear_req_b = 1'b1;
    @(posedge clk);
    #1 clear_req_b = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      exp_we = ((c >= 1 && c <= 10) || c == 14 || c == 15) ? 1 : 0;
      exp_dn = (c == 11 || c == 16) ? 1 : 0;
      exp_a  = (c <= 10) ? c - 1 : c - 14;
      exp_d  = (c <= 10) ? 0 : 1;
      chk("clr_we", 32'(we_b), 32'(exp_we));
      chk("clr_done", 32'(done_b), 32'(exp_dn));
      if (exp_we == 1) begin
        chk("clr_addr", 32'(addr_b), 32'(exp_a));
        chk("clr_data", 32'(data_b), 32'(exp_d));
      end
      if (c == 11) chk("clr_err", 32'(done_err_b), 0);
      if (c == 12) chk("held_ready", 32'(cmd_ready_b), 1);
      if (c == 13) chk("held_busy", 32'(busy_b), 1);
      @(posedge clk);
      #1;
      if (c == 12) cmd_valid_b = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
